// File: rtl/arith_pipe_machine.sv
// -----------------------------------------------------------------------------
// arith_pipe_machine
//   Register file + ALU + iterative shift-add multiplier behind a valid/ready
//   issue port. Every result goes through a one-entry writeback (WB) register
//   and commits to the register file on the following edge. A pending WB entry
//   is forwarded to the operand reads so dependent back-to-back instructions
//   see the new value. Multiply takes WIDTH cycles and holds off issue.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   instruction fields valid      in_ready  block can accept
//   rs, rt, rd register selects              rd_src    1: dest=rt, 0: dest=rd
//   wr_enable  commit result to the file     alu_src2  B operand select
//   alu_op     ALU function                  mul       unsigned multiply
//   imm        immediate
//   dbg_addr   debug read address            dbg_data  committed R[dbg_addr]
//   busy       multiply active or WB pending overflow  last add/sub overflow
//   zero       last result was zero          retired   completed instructions
// -----------------------------------------------------------------------------
module arith_pipe_machine #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int REG_BITS = 5,
  parameter int IMM_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_BITS-1:0] rs,
  input  logic [REG_BITS-1:0] rt,
  input  logic [REG_BITS-1:0] rd,
  input  logic                rd_src,
  input  logic                wr_enable,
  input  logic [1:0]          alu_src2,
  input  logic [2:0]          alu_op,
  input  logic                mul,
  input  logic [IMM_W-1:0]    imm,
  input  logic [REG_BITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]    dbg_data,
  output logic                busy,
  output logic                overflow,
  output logic                zero,
  output logic [31:0]         retired
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_regs [NREGS];
  logic                  r_ready_en;
  logic                  r_wb_valid;
  logic                  r_wb_we;
  logic [REG_BITS-1:0]   r_wb_dest;
  logic [WIDTH-1:0]      r_wb_data;
  logic [WIDTH-1:0]      r_mul_a;
  logic [WIDTH-1:0]      r_mul_b;
  logic [WIDTH-1:0]      r_mul_acc;
  logic [CNT_W-1:0]      r_mul_cnt;
  logic [REG_BITS-1:0]   r_mul_dest;
  logic                  r_mul_we;
  logic                  r_overflow;
  logic                  r_zero;
  logic [31:0]           r_retired;

  logic                  w_accept;
  logic                  w_alu_load;
  logic                  w_mul_start;
  logic                  w_mul_done;
  logic [REG_BITS-1:0]   w_dest;
  logic                  w_wb_fwd_ok;
  logic [WIDTH-1:0]      w_op_a;
  logic [WIDTH-1:0]      w_reg_b;
  logic [WIDTH-1:0]      w_op_b;
  logic [WIDTH-1:0]      w_imm_z;
  logic [WIDTH-1:0]      w_imm_s;
  logic [WIDTH-1:0]      w_imm_hi;
  logic [WIDTH-1:0]      w_alu_res;
  logic                  w_is_addsub;
  logic                  w_alu_ovf;
  logic [WIDTH-1:0]      w_mul_step;

  // in_ready stays low until the first edge after reset release
  assign in_ready    = r_ready_en & (r_state == ST_IDLE);
  assign busy        = (r_state == ST_MUL) | r_wb_valid;
  assign overflow    = r_overflow;
  assign zero        = r_zero;
  assign retired     = r_retired;
  assign w_accept    = in_valid & in_ready;
  assign w_alu_load  = w_accept & ~mul;
  assign w_mul_start = w_accept & mul;
  assign w_mul_done  = (r_state == ST_MUL) & (r_mul_cnt == CNT_W'(32'd1));
  assign w_dest      = rd_src ? rt : rd;
  assign w_wb_fwd_ok = r_wb_valid & r_wb_we & (r_wb_dest != {REG_BITS{1'b0}});
  assign w_imm_z     = WIDTH'(imm);
  assign w_imm_s     = WIDTH'($signed(imm));
  assign w_imm_hi    = w_imm_z << IMM_W;
  assign w_mul_step  = r_mul_acc + (r_mul_b[0] ? r_mul_a : {WIDTH{1'b0}});

  // Debug port shows committed state only; register 0 is forced to zero
  always_comb begin
    dbg_data = {WIDTH{1'b0}};
    if (dbg_addr != {REG_BITS{1'b0}}) begin
      dbg_data = r_regs[dbg_addr];
    end else begin
      dbg_data = {WIDTH{1'b0}};
    end
  end

  // Operand reads with WB forwarding (forwarding never targets register 0)
  always_comb begin
    w_op_a  = {WIDTH{1'b0}};
    w_reg_b = {WIDTH{1'b0}};
    if (w_wb_fwd_ok && (r_wb_dest == rs)) begin
      w_op_a = r_wb_data;
    end else if (rs != {REG_BITS{1'b0}}) begin
      w_op_a = r_regs[rs];
    end else begin
      w_op_a = {WIDTH{1'b0}};
    end
    if (w_wb_fwd_ok && (r_wb_dest == rt)) begin
      w_reg_b = r_wb_data;
    end else if (rt != {REG_BITS{1'b0}}) begin
      w_reg_b = r_regs[rt];
    end else begin
      w_reg_b = {WIDTH{1'b0}};
    end
  end

  // B operand select
  always_comb begin
    w_op_b = w_reg_b;
    case (alu_src2)
      2'b00:   w_op_b = w_reg_b;
      2'b01:   w_op_b = w_imm_s;
      2'b10:   w_op_b = w_imm_z;
      2'b11:   w_op_b = w_imm_hi;
      default: w_op_b = w_reg_b;
    endcase
  end

  // ALU and signed-overflow detection for add/sub
  always_comb begin
    w_alu_res   = {WIDTH{1'b0}};
    w_is_addsub = 1'b0;
    w_alu_ovf   = 1'b0;
    case (alu_op)
      3'b000: w_alu_res = w_op_b;
      3'b001: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      3'b010: begin
        w_alu_res   = w_op_a + w_op_b;
        w_is_addsub = 1'b1;
        w_alu_ovf   = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) &
                      (w_alu_res[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      3'b011: begin
        w_alu_res   = w_op_a - w_op_b;
        w_is_addsub = 1'b1;
        // sub overflows like add with the inverted B operand
        w_alu_ovf   = (w_op_a[WIDTH-1] != w_op_b[WIDTH-1]) &
                      (w_alu_res[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      3'b100: w_alu_res = w_op_a & w_op_b;
      3'b101: w_alu_res = w_op_a | w_op_b;
      3'b110: w_alu_res = ~(w_op_a | w_op_b);
      3'b111: w_alu_res = w_op_a ^ w_op_b;
      default: w_alu_res = {WIDTH{1'b0}};
    endcase
  end

  // FSM next state: leave MUL on the cycle the last step is taken
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mul_start) w_state_next = ST_MUL;
        else             w_state_next = ST_IDLE;
      end
      ST_MUL: begin
        if (w_mul_done) w_state_next = ST_IDLE;
        else            w_state_next = ST_MUL;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath: WB commit, WB load, flags, multiplier and retire counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= {WIDTH{1'b0}};
      r_ready_en <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_dest  <= {REG_BITS{1'b0}};
      r_wb_data  <= {WIDTH{1'b0}};
      r_mul_a    <= {WIDTH{1'b0}};
      r_mul_b    <= {WIDTH{1'b0}};
      r_mul_acc  <= {WIDTH{1'b0}};
      r_mul_cnt  <= {CNT_W{1'b0}};
      r_mul_dest <= {REG_BITS{1'b0}};
      r_mul_we   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_retired  <= 32'd0;
    end else begin
      r_ready_en <= 1'b1;
      // commit of the entry loaded on the previous edge
      if (r_wb_valid) begin
        if (r_wb_we && (r_wb_dest != {REG_BITS{1'b0}})) r_regs[r_wb_dest] <= r_wb_data;
        r_retired <= r_retired + 32'd1;
      end
      // WB may be refilled on the same edge it commits
      if (w_alu_load) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= wr_enable;
        r_wb_dest  <= w_dest;
        r_wb_data  <= w_alu_res;
        r_zero     <= (w_alu_res == {WIDTH{1'b0}});
        if (w_is_addsub) r_overflow <= w_alu_ovf;
      end else if (w_mul_done) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= r_mul_we;
        r_wb_dest  <= r_mul_dest;
        r_wb_data  <= w_mul_step;
        r_zero     <= (w_mul_step == {WIDTH{1'b0}});
      end else begin
        r_wb_valid <= 1'b0;
      end
      if (w_mul_start) begin
        r_mul_a    <= w_op_a;
        r_mul_b    <= w_op_b;
        r_mul_acc  <= {WIDTH{1'b0}};
        r_mul_cnt  <= CNT_W'(WIDTH);
        r_mul_dest <= w_dest;
        r_mul_we   <= wr_enable;
      end else if (r_state == ST_MUL) begin
        r_mul_acc <= w_mul_step;
        r_mul_a   <= r_mul_a << 1;
        r_mul_b   <= r_mul_b >> 1;
        r_mul_cnt <= r_mul_cnt - CNT_W'(32'd1);
      end
    end
  end

endmodule

// File: tb/tb_arith_pipe_machine.sv
module tb_arith_pipe_machine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic        rd_src = 1'b0, wr_enable = 1'b0, mul = 1'b0;
  logic [1:0]  alu_src2 = 2'b00;
  logic [2:0]  alu_op = 3'b000;
  logic [15:0] imm = 16'h0000;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic        busy, overflow, zero;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  arith_pipe_machine dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .rd_src(rd_src), .wr_enable(wr_enable),
    .alu_src2(alu_src2), .alu_op(alu_op), .mul(mul), .imm(imm),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy),
    .overflow(overflow), .zero(zero), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // present one instruction for a single edge (caller ensures in_ready)
  task automatic issue(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rd,
                       input logic a_rd_src, input logic a_we, input logic [1:0] a_src2,
                       input logic [2:0] a_op, input logic a_mul, input logic [15:0] a_imm);
    rs = a_rs; rt = a_rt; rd = a_rd; rd_src = a_rd_src; wr_enable = a_we;
    alu_src2 = a_src2; alu_op = a_op; mul = a_mul; imm = a_imm;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    // reset state
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, overflow, zero}, 32'd0);
    check("rst_retired", retired, 32'd0);
    reset = 1'b1;
    tick();
    check("ready_after_release", {31'd0, in_ready}, 32'd1);

    // multiply aborted by reset in its 10th cycle
    issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 2'b10, 3'b000, 1'b1, 16'h0005);
    repeat (9) tick();
    check("mid_mul_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("abort_ready_after_release", {31'd0, in_ready}, 32'd1);
    repeat (40) tick();
    check("abort_no_retire", retired, 32'd0);
    check("abort_still_idle", {31'd0, busy}, 32'd0);

    // addi R1 = 0 + sext(0x0aaa)
    issue(5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 2'b01, 3'b010, 1'b0, 16'h0aaa);
    check("addi_wb_busy", {31'd0, busy}, 32'd1);
    check_reg("addi_r1_before_commit", 5'd1, 32'h0000_0000);
    tick();
    check_reg("addi_r1", 5'd1, 32'h0000_0aaa);
    check("addi_retired", retired, 32'd1);

    // ori R5 = R1 | 5 ; add R6 = R5 + R5 back to back (forwarded)
    issue(5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0, 16'h0005);
    issue(5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0, 16'h0000);
    check_reg("ori_r5", 5'd5, 32'h0000_0aaf);
    tick();
    check_reg("bypass_r6", 5'd6, 32'h0000_155e);
    check("b2b_retired", retired, 32'd3);

    // R2 = 0x7fffffff built via lui + ori, then add/sub flags
    issue(5'd0, 5'd2, 5'd0, 1'b1, 1'b1, 2'b11, 3'b000, 1'b0, 16'h7fff);
    issue(5'd2, 5'd2, 5'd0, 1'b1, 1'b1, 2'b10, 3'b101, 1'b0, 16'hffff);
    issue(5'd2, 5'd2, 5'd3, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0, 16'h0000);
    check("add_overflow", {31'd0, overflow}, 32'd1);
    check("add_zero", {31'd0, zero}, 32'd0);
    check_reg("lui_ori_r2", 5'd2, 32'h7fff_ffff);
    tick();
    check_reg("add_r3", 5'd3, 32'hffff_fffe);
    issue(5'd3, 5'd3, 5'd4, 1'b0, 1'b1, 2'b00, 3'b011, 1'b0, 16'h0000);
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_overflow", {31'd0, overflow}, 32'd0);
    tick();
    check_reg("sub_r4", 5'd4, 32'h0000_0000);
    check("flags_retired", retired, 32'd7);

    // mul R7 = R1 * R1 = 2730 * 2730 = 7452900 = 0x0071b8e4
    issue(5'd1, 5'd1, 5'd7, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 16'h0000);
    // offered while busy: addi R9 = 0x1234, must be dropped
    rs = 5'd0; rt = 5'd9; rd_src = 1'b1; wr_enable = 1'b1; alu_src2 = 2'b01;
    alu_op = 3'b010; mul = 1'b0; imm = 16'h1234; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("mul_ready_low_cycles", n, 32'd32);
    check("mul_wb_pending", {31'd0, busy}, 32'd1);
    check_reg("mul_r7_before_commit", 5'd7, 32'h0000_0000);
    tick();
    check_reg("mul_r7", 5'd7, 32'h0071_b8e4);
    check_reg("busy_ignored_r9", 5'd9, 32'h0000_0000);
    check("mul_retired", retired, 32'd8);

    // write to R0 then read R0 back to back; sext(0xffff)
    issue(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 16'h1234);
    issue(5'd0, 5'd10, 5'd0, 1'b1, 1'b1, 2'b01, 3'b010, 1'b0, 16'hffff);
    check_reg("r0_stays_zero", 5'd0, 32'h0000_0000);
    check("r0_retired", retired, 32'd9);
    check("sext_add_overflow", {31'd0, overflow}, 32'd0);
    tick();
    check_reg("sext_r10", 5'd10, 32'hffff_ffff);

    // slt signed, xor with zext, nor
    issue(5'd10, 5'd1, 5'd11, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 16'h0000);
    issue(5'd1, 5'd12, 5'd0, 1'b1, 1'b1, 2'b10, 3'b111, 1'b0, 16'hffff);
    issue(5'd0, 5'd0, 5'd13, 1'b0, 1'b1, 2'b00, 3'b110, 1'b0, 16'h0000);
    tick();
    check_reg("slt_r11", 5'd11, 32'h0000_0001);
    check_reg("xor_r12", 5'd12, 32'h0000_f555);
    check_reg("nor_r13", 5'd13, 32'hffff_ffff);
    check("final_retired", retired, 32'd13);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
